spi_mnrch_arb: RTL and testbench

//  Shares one SPI_mnrch instance between two SPI clients: req 0 (inertial sensor

---
 rtl/spi_mnrch_arb_if.sv | 43 ++++
 rtl/spi_mnrch_arb.sv | 177 +++++++++++++++++
 tb/tb_spi_mnrch_arb.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mnrch_arb_if.sv
// Bundle of the two client handshakes and the shared SPI_mnrch connection.
// The slave modport is the arbiter's view; master is the clients/SPI side.
interface spi_mnrch_arb_if;
    // client 0 (inertial sensor interface)
    logic        wrt0;
    logic [15:0] wt_data0;
    logic        busy0;
    logic        done0;
    logic [15:0] rd_data0;
    logic        ovr0;
    // client 1 (A2D / auxiliary sensor)
    logic        wrt1;
    logic [15:0] wt_data1;
    logic        busy1;
    logic        done1;
    logic [15:0] rd_data1;
    logic        ovr1;
    logic        tmo_err;
    // shared SPI_mnrch and per-device chip selects
    logic        spi_wrt;
    logic [15:0] spi_wt_data;
    logic        spi_done;
    logic [15:0] spi_rd_data;
    logic        spi_SS_n;
    logic        SS0_n;
    logic        SS1_n;

    modport slave (
        input  wrt0, wt_data0, wrt1, wt_data1,
        input  spi_done, spi_rd_data, spi_SS_n,
        output busy0, done0, rd_data0, ovr0,
        output busy1, done1, rd_data1, ovr1,
        output tmo_err, spi_wrt, spi_wt_data, SS0_n, SS1_n
    );

    modport master (
        output wrt0, wt_data0, wrt1, wt_data1,
        output spi_done, spi_rd_data, spi_SS_n,
        input  busy0, done0, rd_data0, ovr0,
        input  busy1, done1, rd_data1, ovr1,
        input  tmo_err, spi_wrt, spi_wt_data, SS0_n, SS1_n
    );
endinterface

// File: rtl/spi_mnrch_arb.sv
// Two-client arbiter in front of one SPI_mnrch: one queued command per client,
// serialised issue with an idle gap, chip-select demux and hung-frame abort.
module spi_mnrch_arb #(
    parameter int PRIO_RR    = 1,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 4096
) (
    input logic           clk,
    input logic           rst_n,
    spi_mnrch_arb_if.slave bus
);
    localparam int DATA_W  = 16;
    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   rr_last_q, rr_last_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             pend_q, pend_d;
    logic [1:0][DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0][DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]             done_q, done_d;
    logic [1:0]             ovr_q, ovr_d;
    logic                   spi_wrt_q, spi_wrt_d;
    logic [DATA_W-1:0]      spi_wt_data_q, spi_wt_data_d;
    logic                   tmo_err_q, tmo_err_d;

    logic [1:0]             wrt;
    logic [1:0][DATA_W-1:0] wt_data;
    logic [1:0]             busy;
    logic                   active;
    logic                   grant;

    assign wrt        = {bus.wrt1, bus.wrt0};
    assign wt_data[0] = bus.wt_data0;
    assign wt_data[1] = bus.wt_data1;

    always_comb begin
        active  = (state_q == ISSUE) || (state_q == WAIT);
        busy[0] = pend_q[0] | (active & ~owner_q);
        busy[1] = pend_q[1] | (active & owner_q);
    end

    // rr_last only moves on contested grants, so an uncontested grant never
    // steals the next turn from the other client.
    always_comb begin
        grant = 1'b0;
        if (pend_q == 2'b11) begin
            grant = (PRIO_RR != 0) ? ~rr_last_q : 1'b0;
        end else if (pend_q == 2'b10) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_last_d     = rr_last_q;
        cnt_d         = cnt_q;
        pend_d        = pend_q;
        wdata_d       = wdata_q;
        rd_data_d     = rd_data_q;
        done_d        = 2'b00;
        ovr_d         = 2'b00;
        spi_wrt_d     = 1'b0;
        spi_wt_data_d = spi_wt_data_q;
        tmo_err_d     = tmo_err_q;

        for (int i = 0; i < 2; i++) begin
            if (wrt[i]) begin
                if (busy[i]) begin
                    ovr_d[i] = 1'b1;
                end else begin
                    pend_d[i]  = 1'b1;
                    wdata_d[i] = wt_data[i];
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (pend_q != 2'b00) begin
                    owner_d       = grant;
                    spi_wrt_d     = 1'b1;
                    spi_wt_data_d = wdata_q[grant];
                    state_d       = ISSUE;
                    if (pend_q == 2'b11) begin
                        rr_last_d = grant;
                    end
                end
            end
            ISSUE: begin
                pend_d[owner_q] = 1'b0;
                cnt_d           = '0;
                state_d         = WAIT;
            end
            WAIT: begin
                if (bus.spi_done) begin
                    rd_data_d[owner_q] = bus.spi_rd_data;
                    done_d[owner_q]    = 1'b1;
                    cnt_d              = '0;
                    state_d            = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else if ((TIMEOUT > 0) && (cnt_q == TMO_LAST)) begin
                    rd_data_d[owner_q] = {DATA_W{1'b1}};
                    done_d[owner_q]    = 1'b1;
                    tmo_err_d          = 1'b1;
                    cnt_d              = '0;
                    state_d            = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            rr_last_q     <= 1'b1;
            cnt_q         <= '0;
            pend_q        <= 2'b00;
            wdata_q       <= '0;
            rd_data_q     <= '0;
            done_q        <= 2'b00;
            ovr_q         <= 2'b00;
            spi_wrt_q     <= 1'b0;
            spi_wt_data_q <= '0;
            tmo_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_last_q     <= rr_last_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            wdata_q       <= wdata_d;
            rd_data_q     <= rd_data_d;
            done_q        <= done_d;
            ovr_q         <= ovr_d;
            spi_wrt_q     <= spi_wrt_d;
            spi_wt_data_q <= spi_wt_data_d;
            tmo_err_q     <= tmo_err_d;
        end
    end

    assign bus.busy0       = busy[0];
    assign bus.busy1       = busy[1];
    assign bus.done0       = done_q[0];
    assign bus.done1       = done_q[1];
    assign bus.rd_data0    = rd_data_q[0];
    assign bus.rd_data1    = rd_data_q[1];
    assign bus.ovr0        = ovr_q[0];
    assign bus.ovr1        = ovr_q[1];
    assign bus.tmo_err     = tmo_err_q;
    assign bus.spi_wrt     = spi_wrt_q;
    assign bus.spi_wt_data = spi_wt_data_q;

    // Chip select passes through only to the current owner while its frame is live.
    assign bus.SS0_n = (active && !owner_q) ? bus.spi_SS_n : 1'b1;
    assign bus.SS1_n = (active &&  owner_q) ? bus.spi_SS_n : 1'b1;

    ss_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(!bus.SS0_n && !bus.SS1_n));
endmodule

// File: tb/tb_spi_mnrch_arb.sv
// Bench for spi_mnrch_arb: directed client traffic against a small SPI_mnrch
// model, with a negedge scoreboard for issued commands and returned data.
`timescale 1ns/1ps
module tb_spi_mnrch_arb;
    localparam int SPI_LAT = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_mnrch_arb_if a ();
    spi_mnrch_arb_if b ();

    spi_mnrch_arb #(.PRIO_RR(1), .GAP_CYCLES(4), .TIMEOUT(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a.slave));
    spi_mnrch_arb #(.PRIO_RR(0), .GAP_CYCLES(4), .TIMEOUT(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b.slave));

    typedef struct packed {
        logic        cli;
        logic [15:0] cmd;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [15:0] exp_rd0[$];
    logic [15:0] exp_rd1[$];
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_cnt_a = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] resp(input logic [15:0] c);
        return (c == 16'hA600) ? 16'h1234 : ~c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic unexp(input string name, input logic [31:0] act);
        n_chk++;
        $display("FAIL %s: got event with data %h, expected none", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which: 0 = a.spi_wrt, 1 = a.done0, 2 = a.done1
    task automatic wait_a(input int which, input string name, input int bound);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < bound; i++) begin
            case (which)
                0: hit = a.spi_wrt;
                1: hit = a.done0;
                default: hit = a.done1;
            endcase
            if (hit) break;
            tick();
        end
        if (!hit) begin
            n_chk++;
            $display("FAIL %s: got no event within %0d cycles, expected one", name, bound);
        end
    endtask

    task automatic wait_idle_a(input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            if (!a.busy0 && !a.busy1) break;
            tick();
        end
        if (i == 300) begin
            n_chk++;
            $display("FAIL %s: got busy after 300 cycles, expected idle", name);
        end
        repeat (6) tick();
    endtask

    task automatic drive_a(input logic w0, input logic [15:0] d0,
                           input logic w1, input logic [15:0] d1);
        a.wrt0 = w0; a.wt_data0 = d0;
        a.wrt1 = w1; a.wt_data1 = d1;
        tick();
        a.wrt0 = 1'b0;
        a.wrt1 = 1'b0;
    endtask

    // SPI_mnrch model for A: commands with top nibble E are never answered.
    initial begin : model_a
        logic [15:0] cmd;
        a.spi_SS_n = 1'b1; a.spi_done = 1'b0; a.spi_rd_data = '0;
        forever begin
            tick();
            if (rst_n && a.spi_wrt) begin
                cmd = a.spi_wt_data;
                a.spi_SS_n = 1'b0;
                if (cmd[15:12] == 4'hE) begin
                    for (int i = 0; i < 200; i++) begin
                        tick();
                        if (a.done0 || a.done1 || !rst_n) break;
                    end
                end else begin
                    repeat (SPI_LAT) tick();
                    a.spi_rd_data = resp(cmd);
                    a.spi_done = 1'b1;
                    tick();
                    a.spi_done = 1'b0;
                end
                a.spi_SS_n = 1'b1;
            end
        end
    end

    initial begin : model_b
        logic [15:0] cmd;
        b.spi_SS_n = 1'b1; b.spi_done = 1'b0; b.spi_rd_data = '0;
        forever begin
            tick();
            if (rst_n && b.spi_wrt) begin
                cmd = b.spi_wt_data;
                b.spi_SS_n = 1'b0;
                repeat (SPI_LAT) tick();
                b.spi_rd_data = resp(cmd);
                b.spi_done = 1'b1;
                tick();
                b.spi_done = 1'b0;
                b.spi_SS_n = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : monitor_a
        cmd_t e;
        if (rst_n) begin
            if (a.spi_wrt) begin
                if (exp_cmd.size() == 0) unexp("spi_wrt_extra", a.spi_wt_data);
                else begin
                    e = exp_cmd.pop_front();
                    chk("spi_wt_data", a.spi_wt_data, e.cmd);
                    chk("ss_demux", {a.SS1_n, a.SS0_n}, e.cli ? 2'b01 : 2'b10);
                end
            end
            if (a.done0) begin
                done_cnt_a++;
                if (exp_rd0.size() == 0) unexp("done0_extra", a.rd_data0);
                else chk("rd_data0", a.rd_data0, exp_rd0.pop_front());
            end
            if (a.done1) begin
                done_cnt_a++;
                if (exp_rd1.size() == 0) unexp("done1_extra", a.rd_data1);
                else chk("rd_data1", a.rd_data1, exp_rd1.pop_front());
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish by 1 ms, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int t0, d0, d1, dc;
        bit found;
        a.wrt0 = 0; a.wrt1 = 0; a.wt_data0 = '0; a.wt_data1 = '0;
        b.wrt0 = 0; b.wrt1 = 0; b.wt_data0 = '0; b.wt_data1 = '0;
        repeat (3) tick();
        chk("rst_busy", {a.busy1, a.busy0}, 2'b00);
        chk("rst_done_ovr", {a.done1, a.done0, a.ovr1, a.ovr0}, 4'b0000);
        chk("rst_spi_wrt", a.spi_wrt, 1'b0);
        chk("rst_tmo_err", a.tmo_err, 1'b0);
        chk("rst_ss", {a.SS1_n, a.SS0_n}, 2'b11);
        chk("rst_data", {a.rd_data1, a.rd_data0, a.spi_wt_data}, 48'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Fixed priority starves req 1 while req 0 keeps re-issuing.
        b.wrt0 = 1; b.wt_data0 = 16'h0202; b.wrt1 = 1; b.wt_data1 = 16'h0101;
        tick();
        b.wrt0 = 0; b.wrt1 = 0;
        d0 = 0; d1 = 0;
        for (int f = 0; f < 10; f++) begin
            found = 0;
            for (int i = 0; i < 100; i++) begin
                tick();
                b.wrt0 = 0;
                if (b.done1) d1++;
                if (b.done0) begin found = 1; break; end
            end
            if (!found) begin
                n_chk++;
                $display("FAIL starve_done0: got no done0 in frame %0d, expected one", f);
            end
            d0++;
            b.wrt0 = 1; b.wt_data0 = 16'h0300 + 16'(f);
        end
        tick();
        b.wrt0 = 0;
        chk("starve_done1_count", d1, 0);
        chk("starve_done0_count", d0, 10);
        chk("starve_busy1", b.busy1, 1'b1);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (b.done1) begin found = 1; break; end
            tick();
        end
        chk("starve_done1_eventually", found, 1'b1);
        chk("starve_rd_data1", b.rd_data1, 16'hFEFE);
        chk("starve_rd_data0", b.rd_data0, 16'hFCF6);

        // Single request latency and data return.
        exp_cmd.push_back('{1'b0, 16'hA600});
        exp_rd0.push_back(16'h1234);
        drive_a(1, 16'hA600, 0, 16'h0);
        chk("lat_k1_spi_wrt", a.spi_wrt, 1'b0);
        chk("lat_k1_busy0", a.busy0, 1'b1);
        tick();
        chk("lat_k2_spi_wrt", a.spi_wrt, 1'b1);
        chk("t1_ss1_high", a.SS1_n, 1'b1);
        wait_a(1, "t1_done0", 100);
        chk("t1_busy0_with_done", a.busy0, 1'b0);
        wait_idle_a("t1_idle");
        chk("t1_rd0_held", a.rd_data0, 16'h1234);

        // Simultaneous pairs under round-robin.
        exp_cmd.push_back('{1'b0, 16'h1111});
        exp_cmd.push_back('{1'b1, 16'h2222});
        exp_rd0.push_back(16'hEEEE);
        exp_rd1.push_back(16'hDDDD);
        drive_a(1, 16'h1111, 1, 16'h2222);
        wait_a(1, "t2_done0", 100);
        t0 = cyc;
        wait_a(0, "t2_issue1", 100);
        chk("t2_gap_ge5", (cyc - t0) >= 5, 1'b1);
        wait_a(2, "t2_done1", 100);
        wait_idle_a("t2_idle");
        exp_cmd.push_back('{1'b1, 16'h4444});
        exp_cmd.push_back('{1'b0, 16'h3333});
        exp_rd1.push_back(16'hBBBB);
        exp_rd0.push_back(16'hCCCC);
        drive_a(1, 16'h3333, 1, 16'h4444);
        wait_a(2, "t2b_done1", 100);
        wait_a(1, "t2b_done0", 100);
        wait_idle_a("t2b_idle");

        // Overrun during own WAIT.
        exp_cmd.push_back('{1'b1, 16'h5555});
        exp_rd1.push_back(16'hAAAA);
        drive_a(0, 16'h0, 1, 16'h5555);
        wait_a(0, "t4_issue", 100);
        tick();
        a.wrt1 = 1; a.wt_data1 = 16'h6666;
        tick();
        a.wrt1 = 0;
        chk("t4_ovr1", a.ovr1, 1'b1);
        chk("t4_ovr0", a.ovr0, 1'b0);
        tick();
        chk("t4_ovr1_pulse", a.ovr1, 1'b0);
        wait_a(2, "t4_done1", 100);
        chk("t4_busy1_after", a.busy1, 1'b0);
        wait_idle_a("t4_idle");

        // Timeout, then the pending req 1 is served.
        chk("t5_tmo_before", a.tmo_err, 1'b0);
        exp_cmd.push_back('{1'b0, 16'hE005});
        exp_rd0.push_back(16'hFFFF);
        drive_a(1, 16'hE005, 0, 16'h0);
        wait_a(0, "t5_issue", 100);
        t0 = cyc;
        exp_cmd.push_back('{1'b1, 16'h7777});
        exp_rd1.push_back(16'h8888);
        drive_a(0, 16'h0, 1, 16'h7777);
        wait_a(1, "t5_done0", 200);
        chk("t5_tmo_latency", cyc - t0, 65);
        chk("t5_tmo_err", a.tmo_err, 1'b1);
        wait_a(2, "t5_done1", 100);
        chk("t5_tmo_sticky", a.tmo_err, 1'b1);
        wait_idle_a("t5_idle");

        // Async reset during WAIT.
        exp_cmd.push_back('{1'b0, 16'hE006});
        drive_a(1, 16'hE006, 0, 16'h0);
        wait_a(0, "t6_issue", 100);
        tick();
        tick();
        chk("t6_ss0_low_in_wait", a.SS0_n, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_ss_after_rst", {a.SS1_n, a.SS0_n}, 2'b11);
        chk("t6_busy_after_rst", {a.busy1, a.busy0}, 2'b00);
        chk("t6_tmo_cleared", a.tmo_err, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        dc = done_cnt_a;
        repeat (80) tick();
        chk("t6_no_done", done_cnt_a - dc, 0);
        chk("t6_done_lines", {a.done1, a.done0}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
